// File: rtl/pixel_pkg.sv
// Shared types and width helpers for the pixel array readout block.
package pixel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CONVERT,
    READOUT
  } state_e;

  // Phase counter must reach the longest of erase, expose and the full ramp.
  function automatic int cnt_width(input int erase_cyc, input int expose_cyc, input int data_w);
    int m;
    m = (2 ** data_w) - 1;
    if (erase_cyc - 1 > m) m = erase_cyc - 1;
    if (expose_cyc - 1 > m) m = expose_cyc - 1;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  function automatic int idx_width(input int n_pix);
    return (n_pix <= 1) ? 1 : $clog2(n_pix);
  endfunction

endpackage

// File: rtl/pixel_array_readout_if.sv
// Stream link from the readout block to the downstream consumer.
interface pixel_array_readout_if #(
  parameter int DATA_W = 8
) ();
  logic              valid;
  logic              ready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;

  modport master (output valid, output tlast, output tdata, input ready);
  modport slave  (input valid, input tlast, input tdata, output ready);
endinterface

// File: rtl/pixel_ramp_latch.sv
// Per-pixel ramp code latch: captures the first ramp code at which the
// comparator fires, or the maximum code if it never fires during the ramp.
module pixel_ramp_latch #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              cmp,
  input  logic [DATA_W-1:0] ramp,
  input  logic              sat,
  output logic [DATA_W-1:0] value,
  output logic              done
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      done  <= 1'b0;
    end else if (clr) begin
      value <= '0;
      done  <= 1'b0;
    end else if (en && !done && (cmp || sat)) begin
      value <= cmp ? ramp : '1;
      done  <= 1'b1;
    end
  end

endmodule

// File: rtl/pixel_array_readout.sv
// Frame sequencer for an N_PIX pixel array: erase, expose, shared ramp
// conversion, then streams the latched codes out with tlast on the last pixel.
module pixel_array_readout
  import pixel_pkg::*;
#(
  parameter int N_PIX      = 4,
  parameter int DATA_W     = 8,
  parameter int ERASE_CYC  = 4,
  parameter int EXPOSE_CYC = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic              test_mode,
  input  logic [N_PIX-1:0]  cmp,
  output logic              pix_erase,
  output logic              pix_expose,
  output logic [DATA_W-1:0] ramp,
  output logic              busy,
  output logic              overrun,
  pixel_array_readout_if.master axis
);

  localparam int CNT_W = cnt_width(ERASE_CYC, EXPOSE_CYC, DATA_W);
  localparam int IDX_W = idx_width(N_PIX);

  localparam logic [CNT_W-1:0] ERASE_LAST  = CNT_W'(ERASE_CYC - 1);
  localparam logic [CNT_W-1:0] EXPOSE_LAST = CNT_W'(EXPOSE_CYC - 1);
  localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'((2 ** DATA_W) - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_PIX - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_nxt;
  logic               valid_q, valid_d;
  logic               tlast_q, tlast_d;
  logic [DATA_W-1:0]  tdata_q;
  logic [DATA_W-1:0]  ramp_q;
  logic               pix_erase_q, pix_expose_q, busy_q, overrun_q, tm_q;
  logic               load_code;
  logic [DATA_W-1:0]  code_sel;

  logic               lat_en, lat_sat, lat_clr;
  logic [DATA_W-1:0]  lat_val [N_PIX];
  logic [N_PIX-1:0]   lat_done;

  assign lat_en  = (state_q == CONVERT);
  assign lat_sat = lat_en && (cnt_q == CONV_LAST);
  assign lat_clr = (state_q == IDLE) && trigger;

  for (genvar g = 0; g < N_PIX; g++) begin : g_pix
    pixel_ramp_latch #(.DATA_W(DATA_W)) u_latch (
      .clk   (clk),
      .rst   (rst),
      .clr   (lat_clr),
      .en    (lat_en),
      .cmp   (cmp[g]),
      .ramp  (ramp_q),
      .sat   (lat_sat),
      .value (lat_val[g]),
      .done  (lat_done[g])
    );
  end

  assign idx_nxt = idx_q + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    tlast_d   = tlast_q;
    load_code = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = ERASE;
          cnt_d   = '0;
        end
      end
      ERASE: begin
        if (cnt_q == ERASE_LAST) begin
          state_d = EXPOSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EXPOSE: begin
        if (cnt_q == EXPOSE_LAST) begin
          state_d = CONVERT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CONVERT: begin
        if (cnt_q == CONV_LAST) begin
          state_d   = READOUT;
          cnt_d     = '0;
          idx_d     = '0;
          valid_d   = 1'b1;
          tlast_d   = (IDX_LAST == '0);
          load_code = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READOUT: begin
        if (valid_q && axis.ready) begin
          if (tlast_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            tlast_d = 1'b0;
          end else begin
            idx_d     = idx_nxt;
            tlast_d   = (idx_nxt == IDX_LAST);
            load_code = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Code for the next beat. The first beat is loaded on the same edge as the
  // saturation write, so a pixel not yet done is shown at the maximum code.
  always_comb begin
    code_sel = '0;
    for (int i = 0; i < N_PIX; i++) begin
      if (IDX_W'(i) == idx_d) code_sel = lat_done[i] ? lat_val[i] : '1;
    end
    if (tm_q) code_sel = DATA_W'(idx_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      valid_q      <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      ramp_q       <= '0;
      pix_erase_q  <= 1'b0;
      pix_expose_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      tm_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      valid_q      <= valid_d;
      tlast_q      <= tlast_d;
      ramp_q       <= (state_d == CONVERT) ? cnt_d[DATA_W-1:0] : '0;
      pix_erase_q  <= (state_d == ERASE);
      pix_expose_q <= (state_d == EXPOSE);
      busy_q       <= (state_d != IDLE);
      overrun_q    <= trigger && (state_q != IDLE);
      if (load_code) tdata_q <= code_sel;
      if (lat_clr) tm_q <= test_mode;
    end
  end

  assign pix_erase  = pix_erase_q;
  assign pix_expose = pix_expose_q;
  assign ramp       = ramp_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign axis.valid = valid_q;
  assign axis.tlast = tlast_q;
  assign axis.tdata = tdata_q;

endmodule
